// File: rtl/pkt_mem_tx_if.sv
// Bus between pkt_mem_tx and its length FIFO, packet memory and MAC transmit pins.
// master = the transmitter, slave = the FIFO/memory/MAC environment around it.
interface pkt_mem_tx_if #(
  parameter int pADDR_W = 14,
  parameter int pLEN_W  = 11
);
  logic               i_en;
  logic               i_fifo_empty;
  logic [pLEN_W-1:0]  i_fifo_len;
  logic               o_fifo_rd;
  logic [pADDR_W-1:0] o_mem_addr;
  logic [7:0]         i_mem_data;
  logic               o_tx_en;
  logic [7:0]         o_txd;
  logic               o_busy;
  logic               o_pkt_done;
  logic [pADDR_W-1:0] o_rd_base;

  modport master (
    input  i_en, i_fifo_empty, i_fifo_len, i_mem_data,
    output o_fifo_rd, o_mem_addr, o_tx_en, o_txd, o_busy, o_pkt_done, o_rd_base
  );
  modport slave (
    output i_en, i_fifo_empty, i_fifo_len, i_mem_data,
    input  o_fifo_rd, o_mem_addr, o_tx_en, o_txd, o_busy, o_pkt_done, o_rd_base
  );
endinterface

// File: rtl/pkt_mem_tx.sv
// Replays stored frames as preamble + SFD + data + IFG on a GMII-style byte stream.
// Define TX_APPEND_FCS_EN to append a CRC-32 trailer after the data bytes.
module pkt_mem_tx #(
  parameter int pADDR_W  = 14,
  parameter int pLEN_W   = 11,
  parameter int pPRE_LEN = 7,
  parameter int pIFG     = 12
) (
  input  logic          iclk,
  input  logic          i_rst_n,
  pkt_mem_tx_if.master  bus
);
  localparam int CNT_W = (pLEN_W > 16) ? pLEN_W : 16;
  localparam logic [CNT_W-1:0]   C1       = CNT_W'(1);
  localparam logic [CNT_W-1:0]   PRE_LAST = CNT_W'(pPRE_LEN - 1);
  localparam logic [CNT_W-1:0]   PRE_ADDR = CNT_W'((pPRE_LEN > 1) ? pPRE_LEN - 2 : 0);
  localparam logic [CNT_W-1:0]   IFG_LAST = CNT_W'(pIFG - 1);
  localparam logic [pADDR_W-1:0] A1       = pADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, PRE, SFD, DATA, IFG
`ifdef TX_APPEND_FCS_EN
    , FCS
`endif
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [pLEN_W-1:0]  len;
  logic [pADDR_W-1:0] base;
  logic [CNT_W-1:0]   len_last;

  assign len_last = CNT_W'(len) - C1;

`ifdef TX_APPEND_FCS_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      len            <= '0;
      base           <= '0;
      bus.o_fifo_rd  <= 1'b0;
      bus.o_mem_addr <= '0;
      bus.o_tx_en    <= 1'b0;
      bus.o_txd      <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_pkt_done <= 1'b0;
      bus.o_rd_base  <= '0;
`ifdef TX_APPEND_FCS_EN
      crc            <= '0;
`endif
    end else begin
      bus.o_fifo_rd  <= 1'b0;
      bus.o_pkt_done <= 1'b0;
      case (state)
        IDLE: if (bus.i_en && !bus.i_fifo_empty) begin
          state         <= LOAD;
          bus.o_fifo_rd <= 1'b1;
          bus.o_busy    <= 1'b1;
        end
        LOAD: begin
          len  <= bus.i_fifo_len;
          base <= bus.o_rd_base;
          cnt  <= '0;
`ifdef TX_APPEND_FCS_EN
          crc  <= '1;
`endif
          if (bus.i_fifo_len == '0) begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end else begin
            state       <= PRE;
            bus.o_tx_en <= 1'b1;
            bus.o_txd   <= 8'h55;
            if (pPRE_LEN == 1) bus.o_mem_addr <= bus.o_rd_base;
          end
        end
        PRE: if (cnt == PRE_LAST) begin
          // cnt parks at -1 so SFD and DATA share the "next byte index = cnt+1" path
          state          <= SFD;
          cnt            <= '1;
          bus.o_txd      <= 8'hD5;
          bus.o_mem_addr <= bus.o_mem_addr + A1;
        end else begin
          cnt <= cnt + C1;
          if (pPRE_LEN > 1 && cnt == PRE_ADDR) bus.o_mem_addr <= base;
        end
        SFD, DATA: if (state == DATA && cnt == len_last) begin
          cnt <= '0;
`ifdef TX_APPEND_FCS_EN
          state     <= FCS;
          bus.o_txd <= ~crc[7:0];
          crc       <= crc >> 8;
`else
          state       <= IFG;
          bus.o_tx_en <= 1'b0;
          bus.o_txd   <= '0;
`endif
        end else begin
          state          <= DATA;
          cnt            <= cnt + C1;
          bus.o_txd      <= bus.i_mem_data;
          bus.o_mem_addr <= bus.o_mem_addr + A1;
`ifdef TX_APPEND_FCS_EN
          crc <= crc_byte(crc, bus.i_mem_data);
`endif
          if (cnt + C1 == len_last) begin
            bus.o_rd_base <= base + pADDR_W'(len);
`ifndef TX_APPEND_FCS_EN
            bus.o_pkt_done <= 1'b1;
`endif
          end
        end
`ifdef TX_APPEND_FCS_EN
        FCS: if (cnt == CNT_W'(3)) begin
          state       <= IFG;
          cnt         <= '0;
          bus.o_tx_en <= 1'b0;
          bus.o_txd   <= '0;
        end else begin
          cnt       <= cnt + C1;
          bus.o_txd <= ~crc[7:0];
          crc       <= crc >> 8;
          if (cnt == CNT_W'(2)) bus.o_pkt_done <= 1'b1;
        end
`endif
        IFG: if (cnt == IFG_LAST) begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end else begin
          cnt <= cnt + C1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_mem_tx.sv
// Randomized bench for pkt_mem_tx: a frame-level model expands the queued frames into
// the expected per-cycle pin trace, which is compared against the DUT every cycle.
module tb_pkt_mem_tx;
  localparam int PRE = 7;
  localparam int IFG = 12;
`ifdef TX_APPEND_FCS_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  typedef struct packed {
    logic        en, fifo_rd, busy, tx_en, done;
    logic [7:0]  txd;
    logic [13:0] addr, rd_base;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0]  mem [16384];
  logic [7:0]  mdata = 8'h00;
  logic [10:0] flen [64];
  int fcount = 0;
  int fhead = 0;
  int rd_err = 0;
  int tests = 0;
  int fails = 0;
  logic [13:0] m_addr = '0;
  logic [13:0] m_base = '0;
  cyc_t exq[$];

  always #5 clk = ~clk;

  pkt_mem_tx_if #(.pADDR_W(14), .pLEN_W(11)) bus ();

  pkt_mem_tx #(.pADDR_W(14), .pLEN_W(11), .pPRE_LEN(PRE), .pIFG(IFG)) dut (
    .iclk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  assign bus.i_en         = en;
  assign bus.i_fifo_empty = (fhead >= fcount);
  assign bus.i_fifo_len   = flen[fhead];
  assign bus.i_mem_data   = mdata;

  always @(posedge clk) mdata <= mem[bus.o_mem_addr];

  always @(posedge clk) if (bus.o_fifo_rd) begin
    if (fhead >= fcount) rd_err <= rd_err + 1;
    else fhead <= fhead + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] crc32(input logic [13:0] b, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, mem[b + 14'(i)]};
      repeat (8) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction

  task automatic put(input logic e, input logic fr, input logic bz, input logic te,
                     input logic dn, input logic [7:0] d);
    cyc_t c;
    c.en = e; c.fifo_rd = fr; c.busy = bz; c.tx_en = te; c.done = dn; c.txd = d;
    c.addr = m_addr; c.rd_base = m_base;
    exq.push_back(c);
  endtask

  // Queue one frame in the FIFO and append its expected pin trace.
  task automatic add_frame(input int len, input int wait_n, input bit fixed_fcs);
    logic [13:0] b;
    logic [31:0] fcs;
    flen[fcount] = 11'(len);
    fcount++;
    repeat (wait_n) put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    put(rb(), 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    if (len == 0) return;
    b = m_base;
    fcs = fixed_fcs ? 32'h9BE3E0A3 : crc32(b, len);
    for (int i = 0; i < PRE; i++) begin
      if (i == PRE - 1) m_addr = b;
      put(rb(), 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
    end
    m_addr = b + 14'd1;
    put(rb(), 1'b0, 1'b1, 1'b1, 1'b0, 8'hD5);
    for (int k = 0; k < len; k++) begin
      m_addr = b + 14'(k + 2);
      if (k == len - 1) m_base = b + 14'(len);
      put(rb(), 1'b0, 1'b1, 1'b1, (k == len - 1) && (FCS_N == 0), mem[b + 14'(k)]);
    end
    for (int k = 0; k < FCS_N; k++) put(rb(), 1'b0, 1'b1, 1'b1, k == 3, fcs[8*k +: 8]);
    for (int i = 0; i < IFG; i++) put(rb(), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int sum;
    int rem;
    int l;
    cyc_t c;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    add_frame(4, 0, 1'b0);
    sum = 4;
    if (FCS_N != 0) begin
      mem[4] = 8'h31; mem[5] = 8'h32; mem[6] = 8'h33; mem[7] = 8'h34;
      add_frame(4, 0, 1'b1);
      sum += 4;
    end
    add_frame(3, 0, 1'b0);
    add_frame(5, 0, 1'b0);
    add_frame(0, 0, 1'b0);
    add_frame(2, 0, 1'b0);
    sum += 10;
    for (int i = 0; i < 6; i++) begin
      l = $urandom_range(0, 40);
      add_frame(l, $urandom_range(0, 3), 1'b0);
      sum += l;
    end
    // fill memory so the next frame starts at 16380 and wraps the read pointer
    rem = 16380 - sum;
    while (rem > 0) begin
      l = (rem > 2047) ? 2047 : rem;
      add_frame(l, $urandom_range(0, 2), 1'b0);
      rem -= l;
    end
    add_frame(6, 1, 1'b0);
    repeat (20) put(rb(), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en", 32'(bus.o_tx_en), 32'd0);
    chk("rst_txd", 32'(bus.o_txd), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_fifo_rd", 32'(bus.o_fifo_rd), 32'd0);
    chk("rst_done", 32'(bus.o_pkt_done), 32'd0);
    chk("rst_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("rst_base", 32'(bus.o_rd_base), 32'd0);
    rst_n = 1'b1;

    for (int t = 0; t < exq.size(); t++) begin
      c = exq[t];
      en = c.en;
      chk("tx", 32'({bus.o_tx_en, bus.o_txd}), 32'({c.tx_en, c.txd}));
      chk("ctl", 32'({bus.o_fifo_rd, bus.o_busy, bus.o_pkt_done}), 32'({c.fifo_rd, c.busy, c.done}));
      chk("addr", 32'(bus.o_mem_addr), 32'(c.addr));
      chk("rd_base", 32'(bus.o_rd_base), 32'(c.rd_base));
      if (fails > 40) break;
      @(negedge clk);
    end
    chk("wrap_base", 32'(bus.o_rd_base), 32'd2);
    chk("fifo_drained", 32'(fhead), 32'(fcount));

    // reset during DATA byte 3 of a 10-byte frame based at 2
    flen[fcount] = 11'd10;
    fcount++;
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_frame_start", 32'(bus.o_tx_en), 32'd1);
    repeat (11) @(negedge clk);
    chk("rst_frame_byte3", 32'(bus.o_txd), 32'(mem[14'd5]));
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_en", 32'(bus.o_tx_en), 32'd0);
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    chk("midrst_txd", 32'(bus.o_txd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({bus.o_busy, bus.o_fifo_rd, bus.o_tx_en}), 32'd0);
    end
    chk("post_rst_base", 32'(bus.o_rd_base), 32'd0);
    chk("rd_when_empty", 32'(rd_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
